// File: rtl/mem_access_pkg.sv
// Shared definitions for the MIPS MEM stage: widths, aluop codes,
// SRAM-like bus size codes, FSM state encoding and access decode helpers.
// Optional feature macro: MEM_LWLR_EN (LWL/LWR become word loads with merge).
package mem_access_pkg;

    localparam int unsigned REG_W        = 32;
    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned ALUOP_W      = 8;
    localparam int unsigned INST_ADDR_W  = 32;
    localparam int unsigned SIZE_W       = 2;
    localparam int unsigned STALL_W      = 6;
    localparam int unsigned STALL_MEM_WB = 4;

    localparam logic NO_STOP = 1'b0;

    // Aluop codes seen by the MEM stage
    localparam logic [ALUOP_W-1:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [ALUOP_W-1:0] EXE_ADDU_OP = 8'b0010_0001;
    localparam logic [ALUOP_W-1:0] EXE_LB_OP   = 8'b1110_0000;
    localparam logic [ALUOP_W-1:0] EXE_LH_OP   = 8'b1110_0001;
    localparam logic [ALUOP_W-1:0] EXE_LWL_OP  = 8'b1110_0010;
    localparam logic [ALUOP_W-1:0] EXE_LW_OP   = 8'b1110_0011;
    localparam logic [ALUOP_W-1:0] EXE_LBU_OP  = 8'b1110_0100;
    localparam logic [ALUOP_W-1:0] EXE_LHU_OP  = 8'b1110_0101;
    localparam logic [ALUOP_W-1:0] EXE_LWR_OP  = 8'b1110_0110;
    localparam logic [ALUOP_W-1:0] EXE_SB_OP   = 8'b1110_1000;
    localparam logic [ALUOP_W-1:0] EXE_SH_OP   = 8'b1110_1001;
    localparam logic [ALUOP_W-1:0] EXE_SW_OP   = 8'b1110_1011;

    // SRAM-like data_size encoding
    localparam logic [SIZE_W-1:0] DATA_SIZE_BYTE = 2'd0;
    localparam logic [SIZE_W-1:0] DATA_SIZE_HALF = 2'd1;
    localparam logic [SIZE_W-1:0] DATA_SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        MEM_DONE = 2'd3
    } mem_state_e;

    // Request payload presented on the data bus
    typedef struct packed {
        logic                   wr;
        logic [SIZE_W-1:0]      size;
        logic [INST_ADDR_W-1:0] addr;
        logic [REG_W-1:0]       wdata;
    } mem_req_t;

    function automatic logic is_load(input logic [ALUOP_W-1:0] op);
        logic r;
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: r = 1'b1;
`ifdef MEM_LWLR_EN
            EXE_LWL_OP, EXE_LWR_OP:                                   r = 1'b1;
`endif
            default:                                                  r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_store(input logic [ALUOP_W-1:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    function automatic logic [SIZE_W-1:0] access_size(input logic [ALUOP_W-1:0] op);
        logic [SIZE_W-1:0] r;
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: r = DATA_SIZE_BYTE;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: r = DATA_SIZE_HALF;
            default:                          r = DATA_SIZE_WORD;
        endcase
        return r;
    endfunction

    // LWL/LWR are deliberately absent: they never fault
    function automatic logic misaligned(input logic [ALUOP_W-1:0] op,
                                        input logic [1:0]         a);
        logic r;
        case (op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: r = a[0];
            EXE_LW_OP, EXE_SW_OP:             r = (a != 2'b00);
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load data alignment: picks byte/half from the returned word by address,
// sign/zero extends, and (with MEM_LWLR_EN) merges LWL/LWR with reg2.
module mem_access_load_align
    import mem_access_pkg::*;
(
    input  logic [ALUOP_W-1:0] i_aluop,
    input  logic [1:0]         i_addr,
    input  logic [REG_W-1:0]   i_rdata,
    input  logic [REG_W-1:0]   i_reg2,
    output logic [REG_W-1:0]   o_wdata_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

`ifndef MEM_LWLR_EN
    // reg2 only feeds the unaligned-load merge
    logic w_unused_reg2;
    assign w_unused_reg2 = ^i_reg2;
`endif

    // Little-endian byte and half-word lane selection
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Extension per load type; non-loads produce zero
    always_comb begin
        o_wdata_c = '0;
        case (i_aluop)
            EXE_LB_OP:  o_wdata_c = {{24{w_byte[7]}}, w_byte};
            EXE_LBU_OP: o_wdata_c = {24'h0, w_byte};
            EXE_LH_OP:  o_wdata_c = {{16{w_half[15]}}, w_half};
            EXE_LHU_OP: o_wdata_c = {16'h0, w_half};
            EXE_LW_OP:  o_wdata_c = i_rdata;
`ifdef MEM_LWLR_EN
            EXE_LWL_OP: begin
                case (i_addr)
                    2'd0:    o_wdata_c = {i_rdata[7:0],  i_reg2[23:0]};
                    2'd1:    o_wdata_c = {i_rdata[15:0], i_reg2[15:0]};
                    2'd2:    o_wdata_c = {i_rdata[23:0], i_reg2[7:0]};
                    default: o_wdata_c = i_rdata;
                endcase
            end
            EXE_LWR_OP: begin
                case (i_addr)
                    2'd1:    o_wdata_c = {i_reg2[31:24], i_rdata[31:8]};
                    2'd2:    o_wdata_c = {i_reg2[31:16], i_rdata[31:16]};
                    2'd3:    o_wdata_c = {i_reg2[31:8],  i_rdata[31:24]};
                    default: o_wdata_c = i_rdata;
                endcase
            end
`endif
            default:    o_wdata_c = '0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage of the five-stage MIPS pipeline: issues one SRAM-like
// transaction per load/store, stalls until it completes, aligns load data
// and passes everything else through to MEM/WB.
// Optional feature macro: MEM_LWLR_EN (LWL/LWR as merging word loads).
module mem_access
    import mem_access_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,

    input  logic [REG_ADDR_W-1:0]  wd_i,
    input  logic                   wreg_i,
    input  logic [REG_W-1:0]       wdata_i,
    input  logic [REG_W-1:0]       hi_i,
    input  logic [REG_W-1:0]       lo_i,
    input  logic                   whilo_i,
    input  logic [ALUOP_W-1:0]     aluop_i,
    input  logic [REG_W-1:0]       mem_addr_i,
    input  logic [REG_W-1:0]       reg2_i,
    input  logic                   cp0_reg_we_i,
    input  logic [REG_ADDR_W-1:0]  cp0_reg_write_addr_i,
    input  logic [REG_W-1:0]       cp0_reg_data_i,
    input  logic [INST_ADDR_W-1:0] pc_i,
    input  logic [STALL_W-1:0]     stall,

    output logic                   data_req,
    output logic                   data_wr,
    output logic [SIZE_W-1:0]      data_size,
    output logic [INST_ADDR_W-1:0] data_addr,
    output logic [REG_W-1:0]       data_wdata,
    input  logic                   data_addr_ok,
    input  logic                   data_data_ok,
    input  logic [REG_W-1:0]       data_rdata,

    output logic                   stallreq_mem,

    output logic [REG_ADDR_W-1:0]  wd_o,
    output logic                   wreg_o,
    output logic [REG_W-1:0]       wdata_o,
    output logic [REG_W-1:0]       hi_o,
    output logic [REG_W-1:0]       lo_o,
    output logic                   whilo_o,
    output logic                   cp0_reg_we_o,
    output logic [REG_ADDR_W-1:0]  cp0_reg_write_addr_o,
    output logic [REG_W-1:0]       cp0_reg_data_o,
    output logic [INST_ADDR_W-1:0] pc_o,
    output logic                   adel_o,
    output logic                   ades_o,
    output logic [REG_W-1:0]       badvaddr_o
);

    mem_state_e       r_state;
    mem_state_e       w_next;
    logic [REG_W-1:0] r_rdata_buf;

    logic             w_load;
    logic             w_store;
    logic             w_mem_op;
    logic             w_misalign;
    logic             w_fault;
    logic             w_issue;
    logic             w_lwlr;
    logic             w_capture;
    mem_req_t         w_req;
    logic [REG_W-1:0] w_load_data;

    // Only the MEM/WB hold bit matters here
    logic w_unused_stall;
    assign w_unused_stall = ^{stall[STALL_W-1:STALL_MEM_WB+1], stall[STALL_MEM_WB-1:0]};

    assign w_load     = is_load(aluop_i);
    assign w_store    = is_store(aluop_i);
    assign w_mem_op   = w_load | w_store;
    assign w_misalign = misaligned(aluop_i, mem_addr_i[1:0]);
    assign w_fault    = (r_state == MEM_IDLE) && w_mem_op && w_misalign;
    assign w_issue    = w_mem_op && !w_misalign;

`ifdef MEM_LWLR_EN
    assign w_lwlr = (aluop_i == EXE_LWL_OP) || (aluop_i == EXE_LWR_OP);
`else
    assign w_lwlr = 1'b0;
`endif

    // Request payload: size, word-aligned address for LWL/LWR, replicated store data
    always_comb begin
        w_req.wr    = w_store;
        w_req.size  = access_size(aluop_i);
        w_req.addr  = w_lwlr ? {mem_addr_i[INST_ADDR_W-1:2], 2'b00} : mem_addr_i;
        w_req.wdata = reg2_i;
        case (aluop_i)
            EXE_SB_OP: w_req.wdata = {4{reg2_i[7:0]}};
            EXE_SH_OP: w_req.wdata = {2{reg2_i[15:0]}};
            default:   w_req.wdata = reg2_i;
        endcase
    end

    assign data_wr    = w_req.wr;
    assign data_size  = w_req.size;
    assign data_addr  = w_req.addr;
    assign data_wdata = w_req.wdata;

    // Response data is latched when accepted, either alongside addr_ok or later in WAIT
    assign w_capture = data_data_ok &&
                       ((r_state == MEM_WAIT) || (data_req && data_addr_ok));

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MEM_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            MEM_IDLE: begin
                if (w_issue) begin
                    if (data_addr_ok) begin
                        w_next = data_data_ok ? MEM_DONE : MEM_WAIT;
                    end else begin
                        w_next = MEM_REQ;
                    end
                end
            end
            MEM_REQ: begin
                if (data_addr_ok) begin
                    w_next = data_data_ok ? MEM_DONE : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (data_data_ok) begin
                    w_next = MEM_DONE;
                end
            end
            MEM_DONE: begin
                if (stall[STALL_MEM_WB] == NO_STOP) begin
                    w_next = MEM_IDLE;
                end
            end
            default: w_next = MEM_IDLE;
        endcase
    end

    // FSM outputs: bus request and pipeline stall; both held low while in reset
    always_comb begin
        data_req     = 1'b0;
        stallreq_mem = 1'b0;
        case (r_state)
            MEM_IDLE: begin
                data_req     = w_issue;
                stallreq_mem = w_issue;
            end
            MEM_REQ: begin
                data_req     = 1'b1;
                stallreq_mem = 1'b1;
            end
            MEM_WAIT: begin
                stallreq_mem = 1'b1;
            end
            default: begin
                data_req     = 1'b0;
                stallreq_mem = 1'b0;
            end
        endcase
        if (rst) begin
            data_req     = 1'b0;
            stallreq_mem = 1'b0;
        end
    end

    // Read-data buffer keeps the returned word stable through DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata_buf <= '0;
        end else if (w_capture) begin
            r_rdata_buf <= data_rdata;
        end
    end

    mem_access_load_align u_load_align (
        .i_aluop   (aluop_i),
        .i_addr    (mem_addr_i[1:0]),
        .i_rdata   (r_rdata_buf),
        .i_reg2    (reg2_i),
        .o_wdata_c (w_load_data)
    );

    // Write-back selection and address-error reporting
    always_comb begin
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        adel_o     = 1'b0;
        ades_o     = 1'b0;
        badvaddr_o = '0;
        if (w_fault) begin
            wreg_o     = 1'b0;
            adel_o     = w_load;
            ades_o     = w_store;
            badvaddr_o = mem_addr_i;
        end else if (w_load) begin
            wdata_o = w_load_data;
        end else if (w_store) begin
            wreg_o = 1'b0;
        end
    end

    assign wd_o                 = wd_i;
    assign hi_o                 = hi_i;
    assign lo_o                 = lo_i;
    assign whilo_o              = whilo_i;
    assign cp0_reg_we_o         = cp0_reg_we_i;
    assign cp0_reg_write_addr_o = cp0_reg_write_addr_i;
    assign cp0_reg_data_o       = cp0_reg_data_i;
    assign pc_o                 = pc_i;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: passthrough, loads/stores with various
// response timings, alignment faults, DONE hold and reset mid-access.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i, hi_i, lo_i;
    logic        whilo_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i, reg2_i;
    logic        cp0_reg_we_i;
    logic [4:0]  cp0_reg_write_addr_i;
    logic [31:0] cp0_reg_data_i, pc_i;
    logic [5:0]  stall;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        stallreq_mem;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o, hi_o, lo_o;
    logic        whilo_o, cp0_reg_we_o;
    logic [4:0]  cp0_reg_write_addr_o;
    logic [31:0] cp0_reg_data_o, pc_o;
    logic        adel_o, ades_o;
    logic [31:0] badvaddr_o;

    int n_total = 0;
    int n_bad   = 0;

    logic        f_wr;
    logic [1:0]  f_size;
    logic [31:0] f_addr, f_wdata;
    int          ns, nr;

    mem_access dut (
        .clk(clk), .rst(rst),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i),
        .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
        .cp0_reg_we_i(cp0_reg_we_i), .cp0_reg_write_addr_i(cp0_reg_write_addr_i),
        .cp0_reg_data_i(cp0_reg_data_i), .pc_i(pc_i), .stall(stall),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .stallreq_mem(stallreq_mem),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o),
        .cp0_reg_we_o(cp0_reg_we_o), .cp0_reg_write_addr_o(cp0_reg_write_addr_o),
        .cp0_reg_data_o(cp0_reg_data_o), .pc_o(pc_o),
        .adel_o(adel_o), .ades_o(ades_o), .badvaddr_o(badvaddr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] r2, input logic [31:0] wd);
        aluop_i    = op;
        mem_addr_i = addr;
        reg2_i     = r2;
        wdata_i    = wd;
        wreg_i     = 1'b1;
        wd_i       = 5'd7;
    endtask

    // Drives one access: addr_ok in the first cycle, data_ok dly cycles later.
    // Returns with the bench at the falling edge of the first non-stalled cycle.
    task automatic run_txn(input int dly, input logic [31:0] rd,
                           output int nstall, output int nreq);
        logic done;
        done   = 1'b0;
        nstall = 0;
        nreq   = 0;
        data_addr_ok = 1'b1;
        data_data_ok = (dly == 0);
        data_rdata   = rd;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                f_wr    = data_wr;
                f_size  = data_size;
                f_addr  = data_addr;
                f_wdata = data_wdata;
            end
            if (!stallreq_mem) begin
                done = 1'b1;
            end else begin
                nstall++;
                if (data_req) nreq++;
                @(posedge clk);
                #1;
                data_addr_ok = 1'b0;
                data_data_ok = (c + 1 == dly);
                data_rdata   = data_data_ok ? rd : 32'h5A5A_5A5A;
            end
        end
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        chk("txn_completes", 32'(done), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
        hi_i = 32'h0000_1111; lo_i = 32'h0000_2222; whilo_i = 1'b1;
        aluop_i = EXE_NOP_OP; mem_addr_i = '0; reg2_i = '0;
        cp0_reg_we_i = 1'b1; cp0_reg_write_addr_i = 5'd12; cp0_reg_data_i = 32'hC0C0_0001;
        pc_i = 32'hBFC0_0100; stall = '0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;

        tick; tick;
        @(negedge clk);
        chk("rst_req",   32'(data_req), 32'd0);
        chk("rst_stall", 32'(stallreq_mem), 32'd0);
        tick;
        rst = 1'b0;

        // ADDU passthrough
        set_op(EXE_ADDU_OP, 32'h100, 32'h0, 32'h1234);
        wd_i = 5'd5;
        @(negedge clk);
        chk("addu_wdata", wdata_o, 32'h1234);
        chk("addu_wd",    32'(wd_o), 32'd5);
        chk("addu_wreg",  32'(wreg_o), 32'd1);
        chk("addu_stall", 32'(stallreq_mem), 32'd0);
        chk("addu_req",   32'(data_req), 32'd0);
        chk("addu_hi",    hi_o, 32'h0000_1111);
        chk("addu_cp0",   cp0_reg_data_o, 32'hC0C0_0001);
        chk("addu_pc",    pc_o, 32'hBFC0_0100);
        tick;

        // LB, same-cycle addr_ok/data_ok
        set_op(EXE_LB_OP, 32'h8000_0003, 32'h0, 32'h0);
        run_txn(0, 32'h80FF_0000, ns, nr);
        chk("lb_size",  32'(f_size), 32'd0);
        chk("lb_wr",    32'(f_wr), 32'd0);
        chk("lb_addr",  f_addr, 32'h8000_0003);
        chk("lb_nstall", 32'(ns), 32'd1);
        chk("lb_nreq",  32'(nr), 32'd1);
        chk("lb_wdata", wdata_o, 32'hFFFF_FF80);
        chk("lb_wreg",  32'(wreg_o), 32'd1);
        chk("lb_done_req", 32'(data_req), 32'd0);
        tick;

        // LHU, data_ok three cycles after addr_ok, then hold DONE one cycle
        set_op(EXE_LHU_OP, 32'h2, 32'h0, 32'h0);
        run_txn(3, 32'hBEEF_0000, ns, nr);
        chk("lhu_size",   32'(f_size), 32'd1);
        chk("lhu_nstall", 32'(ns), 32'd4);
        chk("lhu_nreq",   32'(nr), 32'd1);
        chk("lhu_wdata",  wdata_o, 32'h0000_BEEF);
        stall = 6'b01_0000;
        tick;
        @(negedge clk);
        chk("hold_wdata", wdata_o, 32'h0000_BEEF);
        chk("hold_req",   32'(data_req), 32'd0);
        chk("hold_stall", 32'(stallreq_mem), 32'd0);
        stall = '0;
        tick;

        // SB replication
        set_op(EXE_SB_OP, 32'h1, 32'h0000_00A5, 32'h77);
        run_txn(0, 32'h0, ns, nr);
        chk("sb_wr",    32'(f_wr), 32'd1);
        chk("sb_size",  32'(f_size), 32'd0);
        chk("sb_wdata", f_wdata, 32'hA5A5_A5A5);
        chk("sb_addr",  f_addr, 32'h1);
        chk("sb_wreg",  32'(wreg_o), 32'd0);
        chk("sb_pass",  wdata_o, 32'h77);
        tick;

        // SH replication
        set_op(EXE_SH_OP, 32'h2, 32'h1234_ABCD, 32'h0);
        run_txn(0, 32'h0, ns, nr);
        chk("sh_size",  32'(f_size), 32'd1);
        chk("sh_wdata", f_wdata, 32'hABCD_ABCD);
        tick;

        // SW pass-through data
        set_op(EXE_SW_OP, 32'h8, 32'h1122_3344, 32'h0);
        run_txn(0, 32'h0, ns, nr);
        chk("sw_size",  32'(f_size), 32'd2);
        chk("sw_wdata", f_wdata, 32'h1122_3344);
        tick;

        // LH sign extension, upper half
        set_op(EXE_LH_OP, 32'h2, 32'h0, 32'h0);
        run_txn(0, 32'h8001_1234, ns, nr);
        chk("lh_wdata", wdata_o, 32'hFFFF_8001);
        tick;

        // LBU zero extension, one-cycle data delay
        set_op(EXE_LBU_OP, 32'h1, 32'h0, 32'h0);
        run_txn(1, 32'h0000_9A00, ns, nr);
        chk("lbu_nstall", 32'(ns), 32'd2);
        chk("lbu_wdata",  wdata_o, 32'h0000_009A);
        tick;

        // LW aligned
        set_op(EXE_LW_OP, 32'h4, 32'h0, 32'h0);
        run_txn(0, 32'hCAFE_F00D, ns, nr);
        chk("lw_size",  32'(f_size), 32'd2);
        chk("lw_wdata", wdata_o, 32'hCAFE_F00D);
        tick;

        // LW misaligned
        set_op(EXE_LW_OP, 32'h6, 32'h0, 32'h0);
        @(negedge clk);
        chk("lwx_adel",  32'(adel_o), 32'd1);
        chk("lwx_ades",  32'(ades_o), 32'd0);
        chk("lwx_badv",  badvaddr_o, 32'h6);
        chk("lwx_req",   32'(data_req), 32'd0);
        chk("lwx_stall", 32'(stallreq_mem), 32'd0);
        chk("lwx_wreg",  32'(wreg_o), 32'd0);
        tick;

        // SH misaligned
        set_op(EXE_SH_OP, 32'h3, 32'h0, 32'h0);
        @(negedge clk);
        chk("shx_ades", 32'(ades_o), 32'd1);
        chk("shx_adel", 32'(adel_o), 32'd0);
        chk("shx_badv", badvaddr_o, 32'h3);
        chk("shx_req",  32'(data_req), 32'd0);
        tick;

`ifdef MEM_LWLR_EN
        // LWL merge, addr[1:0]=1
        set_op(EXE_LWL_OP, 32'h11, 32'hAABB_CCDD, 32'h0);
        run_txn(0, 32'h4433_2211, ns, nr);
        chk("lwl_addr",  f_addr, 32'h10);
        chk("lwl_wdata", wdata_o, 32'h2211_CCDD);
        tick;
`else
        // LWL treated as non-memory
        set_op(EXE_LWL_OP, 32'h13, 32'hAABB_CCDD, 32'h99);
        @(negedge clk);
        chk("lwl_pass",  wdata_o, 32'h99);
        chk("lwl_req",   32'(data_req), 32'd0);
        chk("lwl_stall", 32'(stallreq_mem), 32'd0);
        chk("lwl_wreg",  32'(wreg_o), 32'd1);
        tick;
`endif

        // Reset while in WAIT
        set_op(EXE_LW_OP, 32'h8, 32'h0, 32'h0);
        data_addr_ok = 1'b1;
        tick;
        data_addr_ok = 1'b0;
        @(negedge clk);
        chk("wait_stall", 32'(stallreq_mem), 32'd1);
        chk("wait_req",   32'(data_req), 32'd0);
        tick;
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_req", 32'(data_req), 32'd0);
        tick;
        rst = 1'b0;
        set_op(EXE_ADDU_OP, 32'h0, 32'h0, 32'h55);
        data_data_ok = 1'b1;
        data_rdata   = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("stray_wdata", wdata_o, 32'h55);
        chk("stray_stall", 32'(stallreq_mem), 32'd0);
        chk("stray_req",   32'(data_req), 32'd0);
        tick;
        data_data_ok = 1'b0;
        set_op(EXE_LW_OP, 32'h8, 32'h0, 32'h0);
        @(negedge clk);
        chk("post_rst_req",   32'(data_req), 32'd1);
        chk("post_rst_stall", 32'(stallreq_mem), 32'd1);
        tick;
        run_txn(0, 32'h0BAD_F00D, ns, nr);
        chk("req_state_nreq", 32'(nr), 32'd1);
        chk("post_rst_wdata", wdata_o, 32'h0BAD_F00D);
        tick;
        set_op(EXE_NOP_OP, 32'h0, 32'h0, 32'h0);
        tick;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
